// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-in, register-file, writeback and operand-out signals of the fetch stage
interface operand_fetch_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        rs1_used;
   logic        rs2_used;
   logic [4:0]  rd;
   logic        rd_write;
   logic [4:0]  rf_addr1;
   logic [4:0]  rf_addr2;
   logic [31:0] rf_data1;
   logic [31:0] rf_data2;
   logic        wb_ena;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  out_rd;
   logic        out_rd_write;
   modport slave (
      input  in_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write,
      input  rf_data1, rf_data2, wb_ena, wb_reg, wb_data, out_ready,
      output in_ready, rf_addr1, rf_addr2, out_valid, op1, op2, out_rd, out_rd_write
   );
   modport master (
      output in_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write,
      output rf_data1, rf_data2, wb_ena, wb_reg, wb_data, out_ready,
      input  in_ready, rf_addr1, rf_addr2, out_valid, op1, op2, out_rd, out_rd_write
   );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand fetch with one-entry output bundle register
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data to pending sources.
module operand_fetch (
   input logic            clk,
   input logic            rst,
   operand_fetch_if.slave bus
);
   logic [31:0] r_pending;
   logic        r_out_valid;
   logic [31:0] r_op1;
   logic [31:0] r_op2;
   logic [4:0]  r_out_rd;
   logic        r_out_rd_write;
   logic        w_hit1;
   logic        w_hit2;
   logic        w_hazard;
   logic        w_ready;
   logic        w_accept;
   logic [31:0] w_src1;
   logic [31:0] w_src2;
   logic [31:0] w_set;
   logic [31:0] w_clr;
   logic [31:0] w_pending_nxt;
`ifdef OPFETCH_BYPASS_EN
   assign w_hit1 = bus.wb_ena && bus.wb_reg == bus.rs1 && bus.wb_reg != 5'd0;
   assign w_hit2 = bus.wb_ena && bus.wb_reg == bus.rs2 && bus.wb_reg != 5'd0;
`else
   assign w_hit1 = 1'b0;
   assign w_hit2 = 1'b0;
`endif
   assign bus.rf_addr1     = bus.rs1;
   assign bus.rf_addr2     = bus.rs2;
   assign bus.in_ready     = w_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.op1          = r_op1;
   assign bus.op2          = r_op2;
   assign bus.out_rd       = r_out_rd;
   assign bus.out_rd_write = r_out_rd_write;
   // hazard detection, handshake, operand selection and scoreboard next state
   always_comb begin
      w_hazard      = (bus.rs1_used && r_pending[bus.rs1] && !w_hit1) ||
                      (bus.rs2_used && r_pending[bus.rs2] && !w_hit2) ||
                      (bus.rd_write && bus.rd != 5'd0 && r_pending[bus.rd]);
      w_ready       = !rst && !w_hazard && (!r_out_valid || bus.out_ready);
      w_accept      = bus.in_valid && w_ready;
      w_src1        = bus.rs1 == 5'd0 ? 32'd0 : w_hit1 ? bus.wb_data : bus.rf_data1;
      w_src2        = bus.rs2 == 5'd0 ? 32'd0 : w_hit2 ? bus.wb_data : bus.rf_data2;
      w_set         = (w_accept && bus.rd_write && bus.rd != 5'd0) ? 32'd1 << bus.rd : 32'd0;
      w_clr         = (bus.wb_ena && bus.wb_reg != 5'd0) ? 32'd1 << bus.wb_reg : 32'd0;
      w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;
   end
   // scoreboard and output bundle registers; a new reservation beats a same-cycle release
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending      <= 32'd0;
         r_out_valid    <= 1'b0;
         r_op1          <= 32'd0;
         r_op2          <= 32'd0;
         r_out_rd       <= 5'd0;
         r_out_rd_write <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_op1          <= w_src1;
            r_op2          <= w_src2;
            r_out_rd       <= bus.rd;
            r_out_rd_write <= bus.rd_write;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed stimulus with a per-cycle reference model and literal spot checks
module tb_operand_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic armed = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   operand_fetch_if bus ();
   operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   bit          pend [32];
   logic        m_valid;
   logic [31:0] m_op1;
   logic [31:0] m_op2;
   logic [4:0]  m_rd;
   logic        m_rdw;
   bit          acc;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic bit byp(logic [4:0] r);
`ifdef OPFETCH_BYPASS_EN
      return bus.wb_ena && bus.wb_reg == r && r != 5'd0;
`else
      return 1'b0 && r != 5'd0;
`endif
   endfunction
   function automatic bit stalled(bit used, logic [4:0] r);
      return used && pend[r] && !byp(r);
   endfunction
   function automatic bit exp_ready();
      if (rst) return 1'b0;
      if (stalled(bus.rs1_used, bus.rs1) || stalled(bus.rs2_used, bus.rs2)) return 1'b0;
      if (bus.rd_write && bus.rd != 5'd0 && pend[bus.rd]) return 1'b0;
      return !m_valid || bus.out_ready;
   endfunction
   function automatic logic [31:0] opnd(logic [4:0] r, logic [31:0] d);
      if (r == 5'd0) return 32'd0;
      return byp(r) ? bus.wb_data : d;
   endfunction
   function automatic logic [31:0] pvec();
      logic [31:0] v = 32'd0;
      for (int i = 0; i < 32; i++) v[i] = pend[i];
      return v;
   endfunction
   // reference model: scoreboard as a bit array, bundle as a held record
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) pend[i] = 1'b0;
         m_valid = 1'b0;
         m_op1 = 32'd0;
         m_op2 = 32'd0;
         m_rd = 5'd0;
         m_rdw = 1'b0;
      end else begin
         acc = bus.in_valid && exp_ready();
         if (bus.wb_ena && bus.wb_reg != 5'd0) pend[bus.wb_reg] = 1'b0;
         if (acc) begin
            m_op1 = opnd(bus.rs1, bus.rf_data1);
            m_op2 = opnd(bus.rs2, bus.rf_data2);
            m_rd = bus.rd;
            m_rdw = bus.rd_write;
            m_valid = 1'b1;
            if (bus.rd_write && bus.rd != 5'd0) pend[bus.rd] = 1'b1;
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
   end
   // per-cycle comparison against the model, away from the clock edge
   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready()});
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
         chk("op1", bus.op1, m_op1);
         chk("op2", bus.op2, m_op2);
         chk("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
         chk("out_rd_write", {31'd0, bus.out_rd_write}, {31'd0, m_rdw});
         chk("rf_addr1", {27'd0, bus.rf_addr1}, {27'd0, bus.rs1});
         chk("rf_addr2", {27'd0, bus.rf_addr2}, {27'd0, bus.rs2});
         chk("pending", dut.r_pending, pvec());
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic instr(logic [4:0] r1, logic u1, logic [4:0] r2, logic u2, logic [4:0] d, logic w);
      bus.in_valid = 1'b1;
      bus.rs1 = r1;
      bus.rs1_used = u1;
      bus.rs2 = r2;
      bus.rs2_used = u2;
      bus.rd = d;
      bus.rd_write = w;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
   initial begin
      bus.in_valid = 1'b0;
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd0;
      bus.rs1_used = 1'b0;
      bus.rs2_used = 1'b0;
      bus.rd = 5'd0;
      bus.rd_write = 1'b0;
      bus.rf_data1 = 32'd0;
      bus.rf_data2 = 32'd0;
      bus.wb_ena = 1'b0;
      bus.wb_reg = 5'd0;
      bus.wb_data = 32'd0;
      bus.out_ready = 1'b1;
      step();
      armed = 1'b1;
      step();
      chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset op1", bus.op1, 32'd0);
      chk("reset pending", dut.r_pending, 32'd0);
      rst = 1'b0;
      // simple fetch
      instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
      bus.rf_data1 = 32'h11;
      bus.rf_data2 = 32'h22;
      #1 chk("first in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk("first out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("first op1", bus.op1, 32'h11);
      chk("first op2", bus.op2, 32'h22);
      // RAW stall on r5, released by writeback
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      step();
      chk("r5 reserved", dut.r_pending, 32'h20);
      instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      bus.rf_data1 = 32'h55;
      #1 chk("raw stall", {31'd0, bus.in_ready}, 32'd0);
      step();
      step();
      bus.wb_ena = 1'b1;
      bus.wb_reg = 5'd5;
      bus.wb_data = 32'hABCD;
`ifdef OPFETCH_BYPASS_EN
      #1 chk("bypass ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.wb_ena = 1'b0;
      bus.in_valid = 1'b0;
      chk("bypass op1", bus.op1, 32'hABCD);
`else
      #1 chk("wb cycle stall", {31'd0, bus.in_ready}, 32'd0);
      step();
      bus.wb_ena = 1'b0;
      bus.rf_data1 = 32'hABCD;
      #1 chk("post wb ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk("rf op1", bus.op1, 32'hABCD);
`endif
      // x0 sources read as zero, x0 destination never reserved
      instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      bus.rf_data1 = 32'hFFFFFFFF;
      bus.rf_data2 = 32'hFFFFFFFF;
      step();
      bus.in_valid = 1'b0;
      chk("x0 op1", bus.op1, 32'd0);
      chk("x0 op2", bus.op2, 32'd0);
      chk("x0 pending", dut.r_pending, 32'd0);
      // backpressure holds bundle, then consume and replace in one cycle
      instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
      bus.rf_data1 = 32'h100;
      bus.rf_data2 = 32'h200;
      step();
      bus.out_ready = 1'b0;
      instr(5'd6, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
      bus.rf_data1 = 32'h600;
      bus.rf_data2 = 32'h700;
      #1 chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp op1 hold", bus.op1, 32'h100);
         chk("bp op2 hold", bus.op2, 32'h200);
      end
      bus.out_ready = 1'b1;
      #1 chk("replace ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk("replace op1", bus.op1, 32'h600);
      chk("replace op2", bus.op2, 32'h700);
      chk("replace valid", {31'd0, bus.out_valid}, 32'd1);
      step();
      chk("drain valid", {31'd0, bus.out_valid}, 32'd0);
      // silent writebacks to non-pending register and to x0
      bus.wb_ena = 1'b1;
      bus.wb_reg = 5'd9;
      step();
      bus.wb_reg = 5'd0;
      step();
      bus.wb_ena = 1'b0;
      chk("silent wb", dut.r_pending, 32'd0);
      // WAW stall is not bypassed
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
      step();
      bus.wb_ena = 1'b1;
      bus.wb_reg = 5'd8;
      #1 chk("waw stall", {31'd0, bus.in_ready}, 32'd0);
      step();
      bus.wb_ena = 1'b0;
      #1 chk("waw release", {31'd0, bus.in_ready}, 32'd1);
      step();
      // reservation beats same-cycle writeback of the same register
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      bus.wb_ena = 1'b1;
      bus.wb_reg = 5'd7;
      step();
      bus.in_valid = 1'b0;
      bus.wb_ena = 1'b0;
      chk("set wins", dut.r_pending, 32'h180);
      chk("pre-rst valid", {31'd0, bus.out_valid}, 32'd1);
      // reset mid-operation
      rst = 1'b1;
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 chk("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst pending", dut.r_pending, 32'd0);
      chk("rst out_rd", {27'd0, bus.out_rd}, 32'd0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
